// File: rtl/clyde_round_ctrl_pkg.sv
// Shared definitions for the Clyde round controller: state encoding,
// default sizing and the layer order of a round in each direction.
package clyde_round_ctrl_pkg;

  localparam int SB_CYCLES_DEF = 3;
  localparam int NSTEPS_DEF    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SB,
    S_LB,
    S_RC,
    S_TK,
    S_DONE
  } state_t;

  // Decryption walks the round layers in reverse: RC -> LB -> SB.
  localparam state_t ENC_FIRST = S_SB;
  localparam state_t ENC_LAST  = S_RC;
  localparam state_t DEC_FIRST = S_RC;
  localparam state_t DEC_LAST  = S_SB;

  function automatic state_t first_phase(input logic dir);
    return dir ? DEC_FIRST : ENC_FIRST;
  endfunction

  function automatic state_t last_phase(input logic dir);
    return dir ? DEC_LAST : ENC_LAST;
  endfunction

endpackage

// File: rtl/clyde_round_ctrl_cnt.sv
// Round counter for the Clyde controller; flags the final round of the
// final step and whether the current round closes a step.
module clyde_round_cnt
  import clyde_round_ctrl_pkg::*;
#(
  parameter int NSTEPS = NSTEPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] round_idx,
  output logic       last_round,
  output logic       odd_round
);

  logic [3:0] round_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_q <= 4'd0;
    end else if (clr) begin
      round_q <= 4'd0;
    end else if (inc) begin
      round_q <= round_q + 4'd1;
    end
  end

  assign round_idx  = round_q;
  assign last_round = (round_q == 4'(2 * NSTEPS - 1));
  assign odd_round  = round_q[0];

endmodule

// File: rtl/clyde_round_ctrl.sv
// Clyde primitive round sequencer: steps the masked S-box, L-box, round
// constant and tweakey layers for encryption or decryption.
module clyde_round_ctrl
  import clyde_round_ctrl_pkg::*;
#(
  parameter int SB_CYCLES = SB_CYCLES_DEF,
  parameter int NSTEPS    = NSTEPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inverse,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       w_syn_init,
  output logic       w_inverse,
  output logic       w_enable,
  output logic       sb_en,
  output logic [3:0] sb_phase,
  output logic       lb_en,
  output logic       rc_add,
  output logic       tk_add,
  output logic [3:0] round_idx
);

  state_t     state_q, state_next;
  logic       dir_q;
  logic       dir_load;
  logic [3:0] sb_cnt_q;
  logic       sb_last;
  logic       round_end;
  logic       round_inc, round_clr;
  logic       last_round, odd_round;

  assign sb_last   = (sb_cnt_q == 4'(SB_CYCLES - 1));
  assign round_end = (state_q == last_phase(dir_q)) && ((state_q != S_SB) || sb_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      sb_cnt_q <= 4'd0;
    end else begin
      state_q <= state_next;
      if (dir_load) begin
        dir_q <= inverse;
      end else if (state_next == S_IDLE) begin
        dir_q <= 1'b0;
      end
      if ((state_q == S_SB) && !sb_last && !abort) begin
        sb_cnt_q <= sb_cnt_q + 4'd1;
      end else begin
        sb_cnt_q <= 4'd0;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    w_syn_init = 1'b0;
    w_enable   = 1'b0;
    sb_en      = 1'b0;
    lb_en      = 1'b0;
    rc_add     = 1'b0;
    tk_add     = 1'b0;
    round_inc  = 1'b0;
    round_clr  = 1'b0;
    dir_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        round_clr = 1'b1;
        if (start) begin
          state_next = S_INIT;
          dir_load   = 1'b1;
        end
      end
      S_INIT: begin
        busy       = 1'b1;
        w_syn_init = 1'b1;
        w_enable   = 1'b1;
        tk_add     = 1'b1;
        state_next = first_phase(dir_q);
      end
      S_SB: begin
        busy  = 1'b1;
        sb_en = 1'b1;
        if (sb_last) state_next = S_LB;
      end
      S_LB: begin
        busy       = 1'b1;
        lb_en      = 1'b1;
        state_next = dir_q ? S_SB : S_RC;
      end
      S_RC: begin
        busy       = 1'b1;
        rc_add     = 1'b1;
        w_enable   = 1'b1;
        state_next = S_LB;
      end
      S_TK: begin
        busy   = 1'b1;
        tk_add = 1'b1;
        if (last_round) begin
          state_next = S_DONE;
          round_clr  = 1'b1;
        end else begin
          state_next = first_phase(dir_q);
          round_inc  = 1'b1;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        round_clr  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // The closing layer of a round overrides the intra-round successor.
    if (round_end) begin
      if (odd_round) begin
        state_next = S_TK;
      end else begin
        state_next = first_phase(dir_q);
        round_inc  = 1'b1;
      end
    end
    if (abort) begin
      state_next = S_IDLE;
      round_clr  = 1'b1;
      round_inc  = 1'b0;
      dir_load   = 1'b0;
    end
  end

  clyde_round_cnt #(
    .NSTEPS(NSTEPS)
  ) u_round_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (round_clr),
    .inc       (round_inc),
    .round_idx (round_idx),
    .last_round(last_round),
    .odd_round (odd_round)
  );

  assign w_inverse = dir_q;
  assign sb_phase  = sb_en ? sb_cnt_q : 4'd0;

endmodule

// File: tb/tb_clyde_round_ctrl.sv
// Directed bench for clyde_round_ctrl: cycle-exact vector table plus
// latency, ordering, abort and reset sequences at SB_CYCLES=3 and 1.
module tb_clyde_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic abort = 1'b0;

  logic       d0_busy, d0_done, d0_syn, d0_winv, d0_wen, d0_sb, d0_lb, d0_rc, d0_tk;
  logic [3:0] d0_ph, d0_ri;
  logic       d1_busy, d1_done, d1_syn, d1_winv, d1_wen, d1_sb, d1_lb, d1_rc, d1_tk;
  logic [3:0] d1_ph, d1_ri;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  clyde_round_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .abort(abort),
    .busy(d0_busy), .done(d0_done), .w_syn_init(d0_syn), .w_inverse(d0_winv),
    .w_enable(d0_wen), .sb_en(d0_sb), .sb_phase(d0_ph), .lb_en(d0_lb),
    .rc_add(d0_rc), .tk_add(d0_tk), .round_idx(d0_ri)
  );

  clyde_round_ctrl #(.SB_CYCLES(1), .NSTEPS(6)) dut1 (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .abort(abort),
    .busy(d1_busy), .done(d1_done), .w_syn_init(d1_syn), .w_inverse(d1_winv),
    .w_enable(d1_wen), .sb_en(d1_sb), .sb_phase(d1_ph), .lb_en(d1_lb),
    .rc_add(d1_rc), .tk_add(d1_tk), .round_idx(d1_ri)
  );

  typedef struct {
    logic        start;
    logic        inverse;
    logic        abort;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[30];

  function automatic logic [16:0] mk(input logic busy, input logic done, input logic syn,
                                     input logic winv, input logic wen, input logic sb,
                                     input logic [3:0] ph, input logic lb, input logic rc,
                                     input logic tk, input logic [3:0] ri);
    return {busy, done, syn, winv, wen, sb, ph, lb, rc, tk, ri};
  endfunction

  function automatic logic [16:0] snap0();
    return mk(d0_busy, d0_done, d0_syn, d0_winv, d0_wen, d0_sb, d0_ph, d0_lb, d0_rc, d0_tk, d0_ri);
  endfunction

  function automatic int phase_code(input logic sb, input logic lb, input logic rc);
    if (sb) return 0;
    if (lb) return 1;
    if (rc) return 2;
    return 3;
  endfunction

  // Legal layer-to-layer moves; code 3 covers both INIT and TK.
  function automatic bit legal(input logic inv, input int p, input int c);
    if (!inv) return (p == 3 && c == 0) || (p == 0 && (c == 0 || c == 1)) ||
                     (p == 1 && c == 2) || (p == 2 && (c == 0 || c == 3));
    return (p == 3 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0) ||
           (p == 0 && (c == 0 || c == 2 || c == 3));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic inv, input int pa, input int pb);
    int lat0 = -1, lat1 = -1, wen0 = 0, oh = 0, ord = 0, winv = 0, nd0 = 0, nd1 = 0;
    int prev = 3, cur;
    inverse = inv;
    start = 1'b1;
    tick();
    start = 1'b0;
    inverse = ~inv;
    for (int c = 1; c <= 120; c++) begin
      if (d0_done) begin nd0++; if (lat0 < 0) lat0 = c; end
      if (d1_done) begin nd1++; if (lat1 < 0) lat1 = c; end
      if (d0_busy) begin
        if ((int'(d0_sb) + int'(d0_lb) + int'(d0_rc) + int'(d0_tk)) != 1) oh++;
        if (d0_wen) wen0++;
        if (d0_winv != inv) winv++;
        cur = phase_code(d0_sb, d0_lb, d0_rc);
        if (c > 1 && !legal(inv, prev, cur)) ord++;
        prev = cur;
      end
      if (d1_busy && (int'(d1_sb) + int'(d1_lb) + int'(d1_rc) + int'(d1_tk)) != 1) oh++;
      start = (c == pa || c == pb);
      tick();
    end
    start = 1'b0;
    check({tag, " latency"}, lat0, 68);
    check({tag, " latency_sb1"}, lat1, 44);
    check({tag, " w_enable_pulses"}, wen0, 13);
    check({tag, " onehot_errors"}, oh, 0);
    check({tag, " order_errors"}, ord, 0);
    check({tag, " w_inverse_errors"}, winv, 0);
    check({tag, " done_count"}, nd0, 1);
    check({tag, " done_count_sb1"}, nd1, 1);
    check({tag, " idle_outputs"}, int'(snap0()), 0);
  endtask

  initial begin
    int k, nd;
    // Cycle-by-cycle expectations: encryption, abort, decryption, abort.
    vecs[0]  = '{1, 0, 0, mk(1,0,1,0,1,0,4'd0,0,0,1,4'd0)};
    vecs[1]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd0,0,0,0,4'd0)};
    vecs[2]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd1,0,0,0,4'd0)};
    vecs[3]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd2,0,0,0,4'd0)};
    vecs[4]  = '{0, 0, 0, mk(1,0,0,0,0,0,4'd0,1,0,0,4'd0)};
    vecs[5]  = '{0, 0, 0, mk(1,0,0,0,1,0,4'd0,0,1,0,4'd0)};
    vecs[6]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd0,0,0,0,4'd1)};
    vecs[7]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd1,0,0,0,4'd1)};
    vecs[8]  = '{0, 0, 0, mk(1,0,0,0,0,1,4'd2,0,0,0,4'd1)};
    vecs[9]  = '{0, 0, 0, mk(1,0,0,0,0,0,4'd0,1,0,0,4'd1)};
    vecs[10] = '{0, 0, 0, mk(1,0,0,0,1,0,4'd0,0,1,0,4'd1)};
    vecs[11] = '{0, 0, 0, mk(1,0,0,0,0,0,4'd0,0,0,1,4'd1)};
    vecs[12] = '{0, 0, 0, mk(1,0,0,0,0,1,4'd0,0,0,0,4'd2)};
    vecs[13] = '{0, 0, 1, mk(0,0,0,0,0,0,4'd0,0,0,0,4'd0)};
    vecs[14] = '{1, 1, 0, mk(1,0,1,1,1,0,4'd0,0,0,1,4'd0)};
    vecs[15] = '{0, 1, 0, mk(1,0,0,1,1,0,4'd0,0,1,0,4'd0)};
    vecs[16] = '{0, 1, 0, mk(1,0,0,1,0,0,4'd0,1,0,0,4'd0)};
    vecs[17] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd0,0,0,0,4'd0)};
    vecs[18] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd1,0,0,0,4'd0)};
    vecs[19] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd2,0,0,0,4'd0)};
    vecs[20] = '{0, 1, 0, mk(1,0,0,1,1,0,4'd0,0,1,0,4'd1)};
    vecs[21] = '{0, 1, 0, mk(1,0,0,1,0,0,4'd0,1,0,0,4'd1)};
    vecs[22] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd0,0,0,0,4'd1)};
    vecs[23] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd1,0,0,0,4'd1)};
    vecs[24] = '{0, 1, 0, mk(1,0,0,1,0,1,4'd2,0,0,0,4'd1)};
    vecs[25] = '{0, 1, 0, mk(1,0,0,1,0,0,4'd0,0,0,1,4'd1)};
    vecs[26] = '{0, 1, 0, mk(1,0,0,1,1,0,4'd0,0,1,0,4'd2)};
    vecs[27] = '{0, 1, 1, mk(0,0,0,0,0,0,4'd0,0,0,0,4'd0)};
    vecs[28] = '{1, 1, 1, mk(0,0,0,0,0,0,4'd0,0,0,0,4'd0)};
    vecs[29] = '{0, 0, 0, mk(0,0,0,0,0,0,4'd0,0,0,0,4'd0)};

    #22;
    check("reset_state", int'(snap0()), 0);
    rst = 1'b1;

    for (int i = 0; i < 30; i++) begin
      start = vecs[i].start;
      inverse = vecs[i].inverse;
      abort = vecs[i].abort;
      tick();
      check($sformatf("vec[%0d]", i), int'(snap0()), int'(vecs[i].exp));
    end
    start = 1'b0;
    abort = 1'b0;
    tick();

    run_op("enc", 1'b0, -1, -1);
    run_op("dec", 1'b1, -1, -1);
    run_op("enc_start_pulses", 1'b0, 10, 30);

    // Abort during SB of round 5.
    inverse = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (d0_ri == 4'd5 && d0_sb) break;
      tick();
    end
    check("abort_target_reached", int'(k < 200), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(d0_busy), 0);
    check("abort_outputs", int'(snap0()), 0);
    nd = 0;
    for (int c = 0; c < 80; c++) begin
      if (d0_done) nd++;
      tick();
    end
    check("abort_no_done", nd, 0);
    run_op("after_abort", 1'b0, -1, -1);

    // Asynchronous reset in the middle of an LB cycle.
    inverse = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (d0_ri == 4'd2 && d0_lb) break;
      tick();
    end
    check("rst_target_reached", int'(k < 200), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_outputs", int'(snap0()), 0);
    check("rst_async_busy_sb1", int'(d1_busy), 0);
    tick();
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 100; c++) begin
      if (d0_done || d1_done) nd++;
      tick();
    end
    check("rst_no_done", nd, 0);
    check("rst_idle_outputs", int'(snap0()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
